// File: rtl/ray_column_renderer_if.sv
// Signal bundle between the raycaster, the player/map side and the VGA/rgb side.
`timescale 1ns/1ps
`default_nettype none

interface ray_column_renderer_if;
   logic           frame_start;
   logic [9:0]     px;
   logic [9:0]     py;
   logic [1:0]     facing;
   logic [0:127]   grid_color;
   logic [9:0]     x_pixel;
   logic [9:0]     y_pixel;
   logic [23:0]    rgb;
   logic           busy;
   logic           done;

   modport master (
      output frame_start, px, py, facing, grid_color, x_pixel, y_pixel,
      input  rgb, busy, done
   );

   modport slave (
      input  frame_start, px, py, facing, grid_color, x_pixel, y_pixel,
      output rgb, busy, done
   );
endinterface

`default_nettype wire

// File: rtl/ray_column_renderer.sv
// ============================================================================
//  Module   : ray_column_renderer
//  Function : per-frame orthographic ray march over the 8x8 map into a
//             double-buffered column table, plus per-pixel 3D-view colouring.
//  Option   : define RAYCOL_SHADE_EN to halve wall colours for hits at d >= 240.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module ray_column_renderer #(
   parameter int NUM_COLS    = 80,
   parameter int COL_WIDTH   = 8,
   parameter int LAT_STEP    = 4,
   parameter int MAX_DIST    = 480,
   parameter int MIN_HEIGHT  = 8,
   parameter int PLAYER_HALF = 10
) (
   input  logic                 clk,
   input  logic                 rst,
   ray_column_renderer_if.slave bus
);
   localparam int C_CW         = $clog2(NUM_COLS);
   localparam int C_COL_SHIFT  = $clog2(COL_WIDTH);
   localparam int C_VIEW_W     = NUM_COLS * COL_WIDTH;
   localparam int C_VIEW_H     = 480;
   localparam int C_CELL_W     = C_VIEW_W / 8;
   localparam int C_CELL_H     = C_VIEW_H / 8;
   localparam int C_HORIZON    = C_VIEW_H / 2;
   localparam int C_SHADE_DIST = 240;

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_LATCH    = 3'd1;
   localparam logic [2:0] S_INIT_COL = 3'd2;
   localparam logic [2:0] S_MARCH    = 3'd3;
   localparam logic [2:0] S_WRITE    = 3'd4;
   localparam logic [2:0] S_NEXT     = 3'd5;
   localparam logic [2:0] S_DONE     = 3'd6;

   localparam logic [2:0] C_KIND_MISS  = 3'd0;
   localparam logic [2:0] C_KIND_BOUND = 3'd4;

   typedef struct packed {
      logic [8:0] h;
      logic [2:0] kind;
   } col_entry_t;

   logic [2:0]         r_state;
   logic [9:0]         r_px;
   logic [9:0]         r_py;
   logic [1:0]         r_facing;
   logic [0:127]       r_grid;
   logic [C_CW-1:0]    r_c;
   logic signed [10:0] r_x;
   logic signed [10:0] r_y;
   logic [8:0]         r_d;
   logic [2:0]         r_kind;
   logic               r_front;
   logic               r_pending;
   logic [23:0]        r_rgb;
   col_entry_t         r_buf [0:1][0:NUM_COLS-1];

   logic signed [10:0] w_cx, w_cy, w_off, w_sx, w_sy;
   logic [2:0]         w_col, w_row;
   logic [1:0]         w_code;
   logic               w_bound;
   logic [8:0]         w_rem, w_height;

   assign w_cx  = $signed({1'b0, r_px}) + $signed(11'(PLAYER_HALF));
   assign w_cy  = $signed({1'b0, r_py}) + $signed(11'(PLAYER_HALF));
   assign w_off = ($signed(11'(r_c)) - $signed(11'(NUM_COLS / 2))) * $signed(11'(LAT_STEP));

   always_comb begin
      w_sx = 11'sd0;
      w_sy = 11'sd0;
      case (r_facing)
         2'd0:    w_sy = -11'sd1;
         2'd1:    w_sx = 11'sd1;
         2'd2:    w_sy = 11'sd1;
         default: w_sx = -11'sd1;
      endcase
   end

   // Cell coordinates by threshold comparison; off-map points are caught by w_bound.
   always_comb begin
      w_col = 3'd0;
      w_row = 3'd0;
      for (int k = 1; k < 8; k++) begin
         if (r_x >= $signed(11'(k * C_CELL_W))) w_col = 3'(k);
         if (r_y >= $signed(11'(k * C_CELL_H))) w_row = 3'(k);
      end
   end

   assign w_code  = r_grid[{w_row, w_col, 1'b0} +: 2];
   assign w_bound = (r_x < 11'sd0) || (r_x >= $signed(11'(C_VIEW_W))) ||
                    (r_y < 11'sd0) || (r_y >= $signed(11'(C_VIEW_H)));

   assign w_rem    = 9'(MAX_DIST) - r_d;
   assign w_height = (r_kind == C_KIND_MISS) ? 9'd0 :
                     (w_rem < 9'(MIN_HEIGHT)) ? 9'(MIN_HEIGHT) : w_rem;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= S_IDLE;
         r_px      <= '0;
         r_py      <= '0;
         r_facing  <= '0;
         r_grid    <= '0;
         r_c       <= '0;
         r_x       <= '0;
         r_y       <= '0;
         r_d       <= '0;
         r_kind    <= '0;
         r_front   <= 1'b0;
         r_pending <= 1'b0;
         for (int b = 0; b < 2; b++)
            for (int i = 0; i < NUM_COLS; i++)
               r_buf[b][i] <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (bus.frame_start) begin
               if (r_pending) begin
                  r_front   <= ~r_front;
                  r_pending <= 1'b0;
               end
               r_state <= S_LATCH;
            end
            S_LATCH: begin
               r_px     <= bus.px;
               r_py     <= bus.py;
               r_facing <= bus.facing;
               r_grid   <= bus.grid_color;
               r_c      <= '0;
               r_state  <= S_INIT_COL;
            end
            S_INIT_COL: begin
               case (r_facing)
                  2'd0:    begin r_x <= w_cx + w_off; r_y <= w_cy;         end
                  2'd1:    begin r_x <= w_cx;         r_y <= w_cy + w_off; end
                  2'd2:    begin r_x <= w_cx - w_off; r_y <= w_cy;         end
                  default: begin r_x <= w_cx;         r_y <= w_cy - w_off; end
               endcase
               r_d     <= '0;
               r_state <= S_MARCH;
            end
            S_MARCH: begin
               if (w_bound) begin
                  r_kind  <= C_KIND_BOUND;
                  r_state <= S_WRITE;
               end else if (w_code != 2'd0) begin
                  r_kind  <= {1'b0, w_code};
                  r_state <= S_WRITE;
               end else if (r_d == 9'(MAX_DIST)) begin
                  r_kind  <= C_KIND_MISS;
                  r_state <= S_WRITE;
               end else begin
                  r_x <= r_x + w_sx;
                  r_y <= r_y + w_sy;
                  r_d <= r_d + 9'd1;
               end
            end
            S_WRITE: begin
               r_buf[~r_front][r_c] <= '{h: w_height, kind: r_kind};
               r_state              <= S_NEXT;
            end
            S_NEXT: begin
               if (r_c == C_CW'(NUM_COLS - 1)) begin
                  r_state <= S_DONE;
               end else begin
                  r_c     <= r_c + 1'b1;
                  r_state <= S_INIT_COL;
               end
            end
            S_DONE: begin
               r_pending <= 1'b1;
               r_state   <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.busy = (r_state != S_IDLE) && (r_state != S_DONE);
   assign bus.done = (r_state == S_DONE);

   logic            w_in_view;
   logic [C_CW-1:0] w_rcol;
   col_entry_t      w_ent;
   logic [8:0]      w_half;
   logic [9:0]      w_top, w_bot;
   logic [23:0]     w_wall, w_pix;

   assign w_in_view = (bus.x_pixel < 10'(C_VIEW_W)) && (bus.y_pixel < 10'(C_VIEW_H));
   assign w_rcol    = w_in_view ? C_CW'(bus.x_pixel >> C_COL_SHIFT) : '0;
   assign w_ent     = r_buf[r_front][w_rcol];
   assign w_half    = w_ent.h >> 1;
   assign w_top     = 10'(C_HORIZON) - {1'b0, w_half};
   assign w_bot     = 10'(C_HORIZON) + {1'b0, w_half};

   always_comb begin
      case (w_ent.kind)
         3'd1:    w_wall = 24'hFF0000;
         3'd2:    w_wall = 24'h00FF00;
         3'd3:    w_wall = 24'h0000FF;
         default: w_wall = 24'hA0A0A0;
      endcase
`ifdef RAYCOL_SHADE_EN
      // Any drawn entry with h <= MAX_DIST-240 came from a hit at d >= 240.
      if (w_ent.h <= 9'(MAX_DIST - C_SHADE_DIST))
         w_wall = {1'b0, w_wall[23:17], 1'b0, w_wall[15:9], 1'b0, w_wall[7:1]};
`endif
      if (bus.y_pixel < w_top)
         w_pix = 24'h202020;
      else if (bus.y_pixel < w_bot)
         w_pix = w_wall;
      else
         w_pix = 24'h404040;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_rgb <= '0;
      else      r_rgb <= w_in_view ? w_pix : 24'h000000;
   end

   assign bus.rgb = r_rgb;
endmodule

`default_nettype wire

// File: tb/tb_ray_column_renderer.sv
// Scoreboard bench for ray_column_renderer with a plain-arithmetic ray-march model.
`timescale 1ns/1ps
`default_nettype none

module tb_ray_column_renderer;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #10 clk = ~clk;

   ray_column_renderer_if bus ();

   ray_column_renderer #(
      .NUM_COLS(80), .COL_WIDTH(8), .LAT_STEP(4),
      .MAX_DIST(480), .MIN_HEIGHT(8), .PLAYER_HALF(10)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int          vectors     = 0;
   int          miscompares = 0;
   int          disp_kind [80];
   int          disp_d    [80];
   int          pend_kind [80];
   int          pend_d    [80];
   bit          pend_valid = 1'b0;
   logic [23:0] exp_q [$];
   int          qx_q  [$];
   int          qy_q  [$];
   bit          qv = 1'b0;

   function automatic int cell_code(input logic [0:127] g, input int x, input int y);
      int i;
      i = (y / 60) * 8 + x / 80;
      return 2 * int'(g[2*i]) + int'(g[2*i+1]);
   endfunction

   // Kind: 0 miss, 1..3 wall code, 4 map boundary. Returns sum of per-column costs.
   function automatic int render(input int px, input int py, input int fac, input logic [0:127] g);
      int s, o, x, y, dx, dy, d, kind;
      bit fin;
      s = 0;
      for (int c = 0; c < 80; c++) begin
         o = (c - 40) * 4;
         case (fac)
            0:       begin x = px + 10 + o; y = py + 10;     dx = 0;  dy = -1; end
            1:       begin x = px + 10;     y = py + 10 + o; dx = 1;  dy = 0;  end
            2:       begin x = px + 10 - o; y = py + 10;     dx = 0;  dy = 1;  end
            default: begin x = px + 10;     y = py + 10 - o; dx = -1; dy = 0;  end
         endcase
         d = 0; kind = 0; fin = 1'b0;
         while (!fin) begin
            if (x < 0 || x > 639 || y < 0 || y > 479) begin kind = 4; fin = 1'b1; end
            else if (cell_code(g, x, y) != 0)          begin kind = cell_code(g, x, y); fin = 1'b1; end
            else if (d == 480)                        begin kind = 0; fin = 1'b1; end
            else begin x += dx; y += dy; d++; end
         end
         pend_kind[c] = kind;
         pend_d[c]    = d;
         s += d + 4;
      end
      return s;
   endfunction

   function automatic logic [23:0] exp_pixel(input int x, input int y);
      int k, d, h, hh;
      logic [23:0] col;
      if (x >= 640 || y >= 480) return 24'h000000;
      k  = disp_kind[x/8];
      d  = disp_d[x/8];
      h  = (k == 0) ? 0 : ((480 - d < 8) ? 8 : 480 - d);
      hh = h / 2;
      if (y < 240 - hh)  return 24'h202020;
      if (y >= 240 + hh) return 24'h404040;
      case (k)
         1:       col = 24'hFF0000;
         2:       col = 24'h00FF00;
         3:       col = 24'h0000FF;
         default: col = 24'hA0A0A0;
      endcase
`ifdef RAYCOL_SHADE_EN
      if (d >= 240) col = (col >> 1) & 24'h7F7F7F;
`endif
      return col;
   endfunction

   function automatic logic [0:127] rand_grid();
      logic [0:127] g;
      logic [1:0]   cd;
      for (int i = 0; i < 64; i++) begin
         cd = ($urandom_range(0, 3) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
         g[2*i]   = cd[1];
         g[2*i+1] = cd[0];
      end
      return g;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic clear_model();
      for (int c = 0; c < 80; c++) begin
         disp_kind[c] = 0;
         disp_d[c]    = 0;
      end
      pend_valid = 1'b0;
   endtask

   task automatic query(input int x, input int y, input bit use_const, input logic [23:0] cval);
      @(posedge clk);
      #1;
      bus.x_pixel = 10'(x);
      bus.y_pixel = 10'(y);
      qv          = 1'b1;
      exp_q.push_back(use_const ? cval : exp_pixel(x, y));
      qx_q.push_back(x);
      qy_q.push_back(y);
   endtask

   task automatic end_queries();
      @(posedge clk);
      #1 qv = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic random_queries(input int n);
      for (int i = 0; i < n; i++)
         query(int'($urandom_range(0, 700)), int'($urandom_range(0, 520)), 1'b0, 24'h0);
   endtask

   task automatic frame(input bit wait_done, input bit disturb);
      int s, n;
      if (pend_valid) begin
         disp_kind  = pend_kind;
         disp_d     = pend_d;
         pend_valid = 1'b0;
      end
      s = render(int'(bus.px), int'(bus.py), int'(bus.facing), bus.grid_color);
      @(posedge clk); #1 bus.frame_start = 1'b1;
      @(posedge clk); #1 bus.frame_start = 1'b0;
      @(negedge clk);
      check("busy_rise", int'(bus.busy), 1);
      if (wait_done) begin
         n = 0;
         while (!bus.done && n < 45000) begin
            n++;
            if (disturb && n == 5) begin
               bus.px          = 10'($urandom_range(0, 629));
               bus.grid_color  = rand_grid();
               bus.frame_start = 1'b1;
            end
            if (disturb && n == 6) bus.frame_start = 1'b0;
            @(negedge clk);
         end
         check("frame_cycles", n, 1 + s);
         check("busy_fall", int'(bus.busy), 0);
         @(negedge clk);
         check("done_pulse", int'(bus.done), 0);
         pend_valid = 1'b1;
      end
   endtask

   initial begin : monitor
      bit          v;
      logic [23:0] e;
      int          x, y;
      forever begin
         @(posedge clk);
         v = qv;
         @(negedge clk);
         if (v) begin
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL pixel: rgb %06h with no expected entry", bus.rgb);
            end else begin
               e = exp_q.pop_front();
               x = qx_q.pop_front();
               y = qy_q.pop_front();
               if (bus.rgb !== e) begin
                  miscompares++;
                  $display("FAIL pixel(%0d,%0d): rgb %06h expected %06h", x, y, bus.rgb, e);
               end
            end
         end
      end
   end

   initial begin : stimulus
      logic [0:127] g;
      bus.frame_start = 1'b0;
      bus.px          = '0;
      bus.py          = '0;
      bus.facing      = '0;
      bus.grid_color  = '0;
      bus.x_pixel     = '0;
      bus.y_pixel     = '0;
      clear_model();

      repeat (3) @(negedge clk);
      check("reset_rgb", int'(bus.rgb), 0);
      check("reset_busy", int'(bus.busy), 0);
      check("reset_done", int'(bus.done), 0);
      rst = 1'b1;

      // Scene A: single red wall cell 4, player centred, facing up.
      g = '0;
      g[9] = 1'b1;
      bus.grid_color = g;
      bus.px = 10'd310; bus.py = 10'd230; bus.facing = 2'd0;
      frame(1'b1, 1'b0);
      query(320, 240, 1'b1, 24'h404040);
      query(320, 90,  1'b1, 24'h202020);
      random_queries(6);
      end_queries();
      frame(1'b0, 1'b0);
      query(320, 240, 1'b1, 24'hFF0000);
      query(320, 90,  1'b1, 24'h202020);
      query(320, 389, 1'b1, 24'h404040);
`ifdef RAYCOL_SHADE_EN
      query(0, 240, 1'b1, 24'h505050);
`else
      query(0, 240, 1'b1, 24'hA0A0A0);
`endif
      query(320, 91, 1'b0, 24'h0);
      query(327, 388, 1'b0, 24'h0);
      query(328, 240, 1'b0, 24'h0);
      query(639, 479, 1'b0, 24'h0);
      query(640, 100, 1'b0, 24'h0);
      random_queries(20);
      end_queries();

      // Reset while the second frame is still rendering.
      check("busy_mid_render", int'(bus.busy), 1);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_busy", int'(bus.busy), 0);
      check("rst_rgb", int'(bus.rgb), 0);
      clear_model();
      repeat (2) @(negedge clk);
      rst = 1'b1;

      // Scene B: off-map origins, walls everywhere except map column 0.
      for (int i = 0; i < 64; i++) begin
         g[2*i]   = (i % 8 != 0);
         g[2*i+1] = 1'b0;
      end
      bus.grid_color = g;
      bus.px = 10'd0; bus.py = 10'd0; bus.facing = 2'd1;
      frame(1'b1, 1'b0);
      query(0, 240, 1'b0, 24'h0);
      random_queries(4);
      end_queries();
      frame(1'b1, 1'b0);
      query(0, 0,   1'b1, 24'hA0A0A0);
      query(0, 479, 1'b1, 24'hA0A0A0);
      query(7, 240, 1'b1, 24'hA0A0A0);
      random_queries(20);
      end_queries();

      // Scenes C/D: random maps; the first is disturbed mid-render.
      for (int sc = 0; sc < 2; sc++) begin
         bus.grid_color = rand_grid();
         bus.px     = 10'($urandom_range(0, 629));
         bus.py     = 10'($urandom_range(0, 469));
         bus.facing = 2'($urandom_range(0, 3));
         frame(1'b1, sc == 0);
         frame(1'b1, 1'b0);
         random_queries(30);
         end_queries();
      end

      check("queue_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

`default_nettype wire
